// File: rtl/raycast_column_scheduler.sv
// Frame sequencer for the slice-height calculator: snapshots the pose, walks every
// column through begin/end handshakes with a watchdog, and hands clamped results to the draw stage.
module raycast_column_scheduler #(
    parameter int NUM_COLS = 160,
    parameter int SCREEN_H = 120,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic signed [12:0] playerX_in,
    input  logic signed [12:0] playerY_in,
    input  logic signed [9:0]  angle_X_in,
    input  logic signed [9:0]  angle_Y_in,
    output logic signed [12:0] calc_playerX,
    output logic signed [12:0] calc_playerY,
    output logic signed [9:0]  calc_angle_X,
    output logic signed [9:0]  calc_angle_Y,
    output logic [7:0]         column_count,
    output logic               begin_calc,
    input  logic               end_calc,
    input  logic [6:0]         slice_size,
    output logic               slice_valid,
    input  logic               slice_ready,
    output logic [7:0]         slice_column,
    output logic [6:0]         slice_height,
    output logic [6:0]         slice_top,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]      LAST_COL   = 8'(NUM_COLS - 1);
    localparam logic [6:0]      SCREEN_H_W = 7'(SCREEN_H);

    logic [2:0]      state;
    logic [WD_W-1:0] watchdog;
    logic [6:0]      clamped_size;

    assign clamped_size = (slice_size > SCREEN_H_W) ? SCREEN_H_W : slice_size;

    // The watchdog is compared against TIMEOUT-1 so that it reaches TIMEOUT on the
    // same edge that forces the column out, giving slice_valid at S+TIMEOUT+1.
    // NOTE: every register here is written with <= so all updates see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            calc_playerX <= '0;
            calc_playerY <= '0;
            calc_angle_X <= '0;
            calc_angle_Y <= '0;
            column_count <= '0;
            watchdog     <= '0;
            slice_column <= '0;
            slice_height <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        calc_playerX <= playerX_in;
                        calc_playerY <= playerY_in;
                        calc_angle_X <= angle_X_in;
                        calc_angle_Y <= angle_Y_in;
                        column_count <= '0;
                        timeout_err  <= 1'b0;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    watchdog <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (end_calc) begin
                        slice_height <= clamped_size;
                        slice_column <= column_count;
                        state        <= S_PRESENT;
                    end else if (watchdog == WD_LAST) begin
                        slice_height <= '0;
                        slice_column <= column_count;
                        timeout_err  <= 1'b1;
                        state        <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (slice_ready) begin
                        if (column_count == LAST_COL) begin
                            state <= S_DONE;
                        end else begin
                            column_count <= column_count + 8'd1;
                            state        <= S_START;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign begin_calc  = (state == S_START);
    assign slice_valid = (state == S_PRESENT);
    assign frame_done  = (state == S_DONE);
    assign frame_busy  = (state != S_IDLE);

    // The clamp bounds slice_height to SCREEN_H, so this subtraction never wraps.
    assign slice_top = (SCREEN_H_W - slice_height) >> 1;

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Scoreboard bench for raycast_column_scheduler with a behavioural slice calculator;
// expected column results are queued at frame issue and popped on each handshake.
module tb_raycast_column_scheduler;

    typedef struct {
        logic [7:0] col;
        logic [6:0] h;
        logic [6:0] t;
    } exp_t;

    logic               clock;
    logic               reset;
    logic               frame_start;
    logic signed [12:0] playerX_in;
    logic signed [12:0] playerY_in;
    logic signed [9:0]  angle_X_in;
    logic signed [9:0]  angle_Y_in;
    logic signed [12:0] calc_playerX;
    logic signed [12:0] calc_playerY;
    logic signed [9:0]  calc_angle_X;
    logic signed [9:0]  calc_angle_Y;
    logic [7:0]         column_count;
    logic               begin_calc;
    logic               end_calc;
    logic [6:0]         slice_size;
    logic               slice_valid;
    logic               slice_ready;
    logic [7:0]         slice_column;
    logic [6:0]         slice_height;
    logic [6:0]         slice_top;
    logic               frame_busy;
    logic               frame_done;
    logic               timeout_err;

    raycast_column_scheduler #(
        .NUM_COLS(4),
        .SCREEN_H(120),
        .TIMEOUT (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .playerX_in  (playerX_in),
        .playerY_in  (playerY_in),
        .angle_X_in  (angle_X_in),
        .angle_Y_in  (angle_Y_in),
        .calc_playerX(calc_playerX),
        .calc_playerY(calc_playerY),
        .calc_angle_X(calc_angle_X),
        .calc_angle_Y(calc_angle_Y),
        .column_count(column_count),
        .begin_calc  (begin_calc),
        .end_calc    (end_calc),
        .slice_size  (slice_size),
        .slice_valid (slice_valid),
        .slice_ready (slice_ready),
        .slice_column(slice_column),
        .slice_height(slice_height),
        .slice_top   (slice_top),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   begin_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    int   sizes[4];
    bit   hang[4];
    int   delay = 2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input int col, input int h, input int t);
        exp_t e;
        e.col = 8'(col);
        e.h   = 7'(h);
        e.t   = 7'(t);
        exp_q.push_back(e);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_end(input string name, input int budget);
        int k;
        for (k = 0; k < budget && frame_busy; k++) tick();
        check({name, "_ended"}, 32'(k < budget), 32'd1);
    endtask

    // Behavioural slice calculator: replies `delay` cycles after begin_calc unless told to hang.
    initial begin
        int  cnt;
        bit  pending;
        logic [6:0] pend_size;
        pending  = 1'b0;
        end_calc = 1'b0;
        slice_size = '0;
        forever begin
            @(negedge clock);
            end_calc = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        end_calc   = 1'b1;
                        slice_size = pend_size;
                        pending    = 1'b0;
                    end
                end
                if (begin_calc && !hang[column_count[1:0]]) begin
                    pending   = 1'b1;
                    cnt       = delay;
                    pend_size = 7'(sizes[column_count[1:0]]);
                end
            end
        end
    end

    // Monitor: event counters plus scoreboard pop on every accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (begin_calc) begin_cnt++;
                if (frame_done) done_cnt++;
                if (slice_valid && slice_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: column %0d height %0d, expected no result",
                                 slice_column, slice_height);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_col_h_top", 32'({slice_column, slice_height, slice_top}),
                              32'({e.col, e.h, e.t}));
                    end
                end
            end
        end
    end

    initial begin
        int b0, d0, k;
        logic [21:0] held;
        bit stable;

        reset = 1'b1;
        frame_start = 1'b0;
        slice_ready = 1'b1;
        playerX_in = '0;
        playerY_in = '0;
        angle_X_in = '0;
        angle_Y_in = '0;
        for (int i = 0; i < 4; i++) begin
            sizes[i] = 0;
            hang[i]  = 1'b0;
        end

        // Reset state
        tick(3);
        check("rst_pose", 32'({calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y}), 32'd0);
        check("rst_ctrl", 32'({begin_calc, slice_valid, frame_busy, frame_done, timeout_err}), 32'd0);
        check("rst_result", 32'({column_count, slice_column, slice_height}), 32'd0);
        check("rst_top", 32'(slice_top), 32'd60);
        reset = 1'b0;
        tick();

        // Nominal frame: all heights 40
        for (int i = 0; i < 4; i++) begin
            sizes[i] = 40;
            push_exp(i, 40, 40);
        end
        playerX_in = 13'sd100;
        playerY_in = -13'sd7;
        angle_X_in = 10'sd3;
        angle_Y_in = 10'sd200;
        b0 = begin_cnt;
        d0 = done_cnt;
        start_frame();
        check("accept_begin", 32'({begin_calc, frame_busy}), 32'b11);
        check("accept_pose", 32'(calc_playerX), 32'd100);
        check("accept_pose_y", 32'(calc_playerY), 32'hFFFF_FFF9);
        check("accept_angles", 32'({calc_angle_X, calc_angle_Y}), 32'({10'sd3, 10'sd200}));
        wait_frame_end("nominal", 100);
        tick();
        check("nominal_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("nominal_begin_cnt", 32'(begin_cnt - b0), 32'd4);
        check("nominal_tmo", 32'(timeout_err), 32'd0);

        // Clamp and zero heights
        sizes = '{127, 0, 120, 121};
        push_exp(0, 120, 0);
        push_exp(1, 0, 60);
        push_exp(2, 120, 0);
        push_exp(3, 120, 0);
        start_frame();
        wait_frame_end("clamp", 100);
        tick();

        // Backpressure on column 0
        sizes = '{5, 6, 7, 8};
        push_exp(0, 5, 57);
        push_exp(1, 6, 57);
        push_exp(2, 7, 56);
        push_exp(3, 8, 56);
        slice_ready = 1'b0;
        start_frame();
        for (k = 0; k < 20 && !slice_valid; k++) tick();
        check("bp_valid_seen", 32'(k < 20), 32'd1);
        held = {slice_column, slice_height, slice_top};
        b0 = begin_cnt;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!slice_valid || begin_calc || column_count != 8'd0 ||
                {slice_column, slice_height, slice_top} != held) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_no_begin", 32'(begin_cnt - b0), 32'd0);
        slice_ready = 1'b1;
        tick();
        check("bp_release", 32'({begin_calc, column_count}), 32'({1'b1, 8'd1}));
        wait_frame_end("bp", 100);
        tick();

        // Timeout on column 2
        sizes = '{50, 60, 0, 70};
        hang[2] = 1'b1;
        push_exp(0, 50, 35);
        push_exp(1, 60, 30);
        push_exp(2, 0, 60);
        push_exp(3, 70, 25);
        start_frame();
        for (k = 0; k < 50 && !(begin_calc && column_count == 8'd2); k++) tick();
        check("tmo_col2_begin", 32'(k < 50), 32'd1);
        check("tmo_clear_before", 32'(timeout_err), 32'd0);
        k = 0;
        while (!slice_valid && k < 30) begin
            tick();
            k++;
        end
        check("tmo_latency", 32'(k), 32'd9);
        check("tmo_flag", 32'({timeout_err, slice_height}), 32'({1'b1, 7'd0}));
        wait_frame_end("tmo", 100);
        tick();
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        hang[2] = 1'b0;

        // Pose snapshot and ignored mid-frame start
        for (int i = 0; i < 4; i++) begin
            sizes[i] = 10;
            push_exp(i, 10, 55);
        end
        playerX_in = 13'sd200;
        b0 = begin_cnt;
        d0 = done_cnt;
        start_frame();
        check("restart_clears_tmo", 32'(timeout_err), 32'd0);
        check("snap_capture", 32'(calc_playerX), 32'd200);
        tick(4);
        playerX_in = -13'sd5;
        start_frame();
        check("snap_hold", 32'(calc_playerX), 32'd200);
        wait_frame_end("snap", 100);
        tick();
        check("snap_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("snap_begin_cnt", 32'(begin_cnt - b0), 32'd4);
        check("snap_after", 32'(calc_playerX), 32'd200);

        // Reset during WAIT of column 1
        delay = 5;
        sizes = '{30, 30, 30, 30};
        push_exp(0, 30, 45);
        d0 = done_cnt;
        start_frame();
        for (k = 0; k < 50 && !(begin_calc && column_count == 8'd1); k++) tick();
        check("rst_mid_reach", 32'(k < 50), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_pose", 32'({calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y}), 32'd0);
        check("rst_mid_ctrl", 32'({begin_calc, slice_valid, frame_busy, frame_done, timeout_err}), 32'd0);
        check("rst_mid_result", 32'({column_count, slice_column, slice_height, slice_top}),
              32'({8'd0, 8'd0, 7'd0, 7'd60}));
        reset = 1'b0;
        tick(2);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        delay = 2;
        sizes = '{40, 40, 40, 40};
        for (int i = 0; i < 4; i++) push_exp(i, 40, 40);
        start_frame();
        check("rst_restart_col0", 32'({begin_calc, column_count}), 32'({1'b1, 8'd0}));
        wait_frame_end("rst_restart", 100);
        tick();
        check("rst_restart_done", 32'(done_cnt - d0), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raycast_column_scheduler.md
# raycast_column_scheduler

Frame-level sequencer for the slice-height calculator. On a frame request it snapshots the player pose and sweeps `column_count` from 0 to NUM_COLS-1. For each column it pulses `begin_calc`, waits for `end_calc` under a watchdog, and clamps the returned `slice_size`. It then presents the column, height and top row to the column-draw stage over a valid/ready handshake. It sits between the game-state/input logic and the slice calculator, and feeds the VGA column renderer.

## Interface
- NUM_COLS, 160, columns per frame (0.375° per column across a 60° FOV); must be ≤ 256
- SCREEN_H, 120, screen height in rows; heights are clamped to this value
- TIMEOUT, 1023, cycles allowed between `begin_calc` and `end_calc` before the column is forced to 0

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  request a new frame; honoured only in IDLE
- playerX_in, playerY_in  in  13 signed  live player position
- angle_X_in, angle_Y_in  in  10 signed  live view angle (integer / fraction parts)
- calc_playerX, calc_playerY  out  13 signed  pose snapshot driven to the slice calculator
- calc_angle_X, calc_angle_Y  out  10 signed  angle snapshot driven to the slice calculator
- column_count  out  8  current column index
- begin_calc  out  1  one-cycle start pulse to the slice calculator
- end_calc  in  1  slice calculator done
- slice_size  in  7  slice height from the calculator
- slice_valid  out  1  column result available
- slice_ready  in  1  draw stage accepts the result
- slice_column  out  8  column of the presented result
- slice_height  out  7  clamped height
- slice_top  out  7  first row = (SCREEN_H − slice_height) >> 1
- frame_busy  out  1  high from frame accept until DONE
- frame_done  out  1  one-cycle pulse when the last column is accepted
- timeout_err  out  1  sticky: some column in this frame timed out

## Operation
- States: IDLE, START, WAIT, PRESENT, DONE.
- IDLE:
  - If `frame_start` = 1: capture the four pose inputs into the calc_* registers, set column_count←0, clear timeout_err, go to START.
  - Otherwise stay in IDLE.
- START:
  - begin_calc=1 for this one cycle.
  - Watchdog←0.
  - Go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If `end_calc` = 1: slice_height←min(slice_size, SCREEN_H), slice_column←column_count, go to PRESENT.
  - Else if watchdog == TIMEOUT: slice_height←0, timeout_err←1, go to PRESENT.
  - If `end_calc` and the timeout condition occur in the same cycle, `end_calc` wins.
- PRESENT:
  - slice_valid=1; slice_column, slice_height and slice_top are held stable until the handshake (slice_valid & slice_ready).
  - On handshake, if column_count == NUM_COLS−1, go to DONE.
  - On handshake otherwise, column_count increments and go to START.
- DONE:
  - frame_done=1 for one cycle.
  - Go to IDLE.
- frame_busy=1 in START, WAIT, PRESENT and DONE.
- `frame_start` outside IDLE is ignored; it is not queued.
- `end_calc` outside WAIT is ignored.
- The pose snapshot is constant for the whole frame; changes on the live inputs take effect at the next frame.
- Height 0 (no wall found) is a valid result and is presented normally; slice_top = SCREEN_H/2 in that case.
- slice_top is computed combinationally from the registered slice_height using unsigned 7-bit arithmetic. No underflow is possible because of the clamp.

## Timing
- Reset:
  - state=IDLE.
  - All outputs 0: calc_* registers, column_count, begin_calc, slice_valid, slice_column, slice_height, frame_busy, frame_done, timeout_err.
  - slice_top = SCREEN_H>>1 (derived from slice_height=0).
- Reset mid-frame: the frame is aborted, with no frame_done pulse and no slice_valid. The top level resets the slice calculator with the same signal.
- Frame accept:
  - `frame_start` sampled at edge N.
  - begin_calc high during cycle N+1.
- Result latency: `end_calc` sampled at edge t gives slice_valid=1 from t+1.
- Next column: handshake at edge t gives begin_calc for the next column during cycle t+1.
- Minimum per column is 3 cycles (START, WAIT, PRESENT with ready held high and end_calc returning after 1 cycle).
- Timeout:
  - begin_calc at cycle S with no end_calc.
  - The watchdog reaches TIMEOUT at the edge ending cycle S+TIMEOUT.
  - slice_valid with height 0 follows at S+TIMEOUT+1.
- frame_done rises exactly 1 cycle after the final handshake edge.

## Test plan
- Nominal frame, NUM_COLS=4, model returns end_calc 2 cycles after begin_calc with slice_size=40, slice_ready tied 1: 4 results for columns 0..3, height 40, top 40; frame_done once; 4 begin_calc pulses total.
- Clamp and zero: slice_size=127 → height 120, top 0; slice_size=0 → height 0, top 60.
- Backpressure: hold slice_ready=0 for 10 cycles in PRESENT → outputs stable, no new begin_calc, column_count unchanged; releasing ready → next begin_calc the following cycle.
- Timeout with TIMEOUT=8: never assert end_calc for column 2 → column 2 presented with height 0, timeout_err=1 through frame end; the next frame_start clears it.
- Pose snapshot and ignored start: change playerX_in and pulse frame_start mid-frame → calc_playerX unchanged, no restart, single frame_done.
- Reset during WAIT of column 1 → all outputs 0 next cycle, state IDLE; a new frame_start starts again at column 0.
